mem_wait_unit: RTL and testbench
================================

Name: mem_wait_unit

Overview:
Word-organised unified instruction/data memory with a variable-latency valid/ready handshake. It sits directly downstream of the multi-cycle CPU datapath's memory-address mux and feeds the IR and MDR registers. It replaces the zero-wait memory so the control FSM can be exercised against realistic wait states. The unit accepts one request at a time, models a fixed access latency, and flags misaligned accesses.

Parameters:
ADDR_W, 10, word-address width; array depth = 2**ADDR_W 32-bit words.
LATENCY, 2, number of WAIT cycles per access; legal range 1..15.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_we  in  1  1 = write, 0 = read.
req_addr  in  32  byte address.
req_wdata  in  32  write data.
req_ready  out  1  unit can accept a request this cycle.
resp_valid  out  1  one-cycle pulse: access complete.
resp_rdata  out  32  read data, or the prior word contents for a write.
resp_err  out  1  misaligned request, qualified by resp_valid.
busy  out  1  high in WAIT and RESP.

Behaviour:
- Interface: one clock (clk); synchronous, active-high reset (reset).
- FSM states: IDLE, WAIT, RESP.
- req_ready = (state == IDLE) && !reset. busy = (state != IDLE).
- Handshake: a request is accepted on a rising edge where req_valid && req_ready.
  - At acceptance, capture addr, we and wdata.
  - Inputs are ignored in all other cycles, so the requester may change them freely.
- IDLE, request accepted:
  - req_addr[1:0] != 0: go to RESP with the error flag set. No array access occurs.
  - Otherwise: load wait counter = LATENCY-1 and go to WAIT.
- WAIT: counter decrements each cycle. On the edge where counter == 0:
  - Read the word at index = addr[ADDR_W+1:2] into the response register.
  - If writing, write wdata to the same index on that same edge (read-before-write).
  - Go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE. There is no resp_ready; the consumer must sample in that cycle.
- Response data for a misaligned request: resp_rdata = 0.
- Latency: request accepted at edge 0 gives resp_valid high during cycle LATENCY+1. Misaligned requests: resp_valid high in cycle 1.
- Throughput: at most one access per LATENCY+2 cycles. A req_valid held high through RESP is accepted on the first IDLE edge after it.
- Address wrap: req_addr bits above ADDR_W+1 are ignored, so addresses alias modulo 4*2**ADDR_W bytes.
- Hold rules:
  - resp_rdata and resp_err hold their last values until the next response is produced.
  - resp_valid is the only pulse output.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; resp_err 0; busy 0; counter 0; req_ready 0 while reset is high.
- Array contents are not cleared by reset. After power-up they are undefined, except with the optional preload feature.
- Reset mid-operation: reset asserted in WAIT abandons the access. A pending write is not performed, and no resp_valid is issued.
- Simultaneous events: if reset and req_valid are high in the same cycle, reset wins and nothing is accepted.

Optional Feature:
MEM_WAIT_PRELOAD_EN
- Defined: adds parameter INIT_FILE (default "mem.dat"). The array is loaded with $readmemh at time zero, for program images.
- Not defined: no preload. The array starts undefined and is filled only by writes.
- Handshake timing is identical in both builds.

Test Plan:
- Reset, then read: hold reset 2 cycles, then read addr 0x0 -> req_ready=0 during reset, then 1; resp_valid at cycle 3; resp_rdata unchanged; no error.
- Write then read (LATENCY=2): write 0xDEADBEEF to 0x10 -> resp_valid at cycle 3 with resp_rdata = old word. Then read 0x10 -> resp_rdata = 0xDEADBEEF.
- Misaligned: write to 0x13 -> resp_valid at cycle 1, resp_err=1, resp_rdata=0. A later read of 0x10 still returns 0xDEADBEEF.
- Alias/wrap (ADDR_W=10): write 0x12345678 to 0x1004 -> read of 0x0004 returns 0x12345678.
- Reset mid-write: write 0xAAAA5555 to 0x20; assert reset in the first WAIT cycle -> no resp_valid. A read of 0x20 after reset returns the prior contents.
- Back-to-back with LATENCY=4: hold req_valid high for 3 reads -> responses 6 cycles apart; req_ready low during each access; busy high throughout each access.

Source files
------------

// File: rtl/mem_wait_unit.sv
// Word-organised unified memory with a fixed-latency valid/ready handshake and misalignment flagging.
// Optional build macro MEM_WAIT_PRELOAD_EN adds the INIT_FILE parameter.
module mem_wait_unit #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
`ifdef MEM_WAIT_PRELOAD_EN
    ,
    parameter     INIT_FILE = "mem.dat"
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic              rd_sel_q, rd_sel_d;
    logic [31:0]       rd_word_q;
    logic [31:0]       mem [DEPTH];

    logic accept;
    logic mem_fire;
    logic unused_addr_hi;

    // Upper address bits alias away; fold them so they are visibly consumed.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign req_ready  = (state_q == S_IDLE) && !reset;
    assign busy       = (state_q != S_IDLE);
    assign accept     = req_valid && req_ready;
    assign mem_fire   = (state_q == S_WAIT) && (cnt_q == 4'd0) && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    // Read word lives in the RAM output register; misaligned and reset responses read as zero.
    assign resp_rdata = rd_sel_q ? rd_word_q : 32'd0;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        rd_sel_d     = rd_sel_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d   = req_addr[ADDR_W+1:2];
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    if (req_addr[1:0] != 2'b00) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        rd_sel_d     = 1'b0;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    rd_sel_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            idx_q        <= '0;
            we_q         <= 1'b0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    // Contents survive reset; the read returns the old word even when writing the same index.
    always_ff @(posedge clk) begin
        if (mem_fire) begin
            rd_word_q <= mem[idx_q];
            if (we_q) begin
                mem[idx_q] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_unit.sv
// Bench for mem_wait_unit: table-driven accesses on a LATENCY=2 instance with a response
// scoreboard, plus hand sequences for reset, abandoned writes and LATENCY=4 back-to-back timing.
module tb_mem_wait_unit;

    localparam int LAT_A = 2;
    localparam int LAT_B = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;

    logic        req_valid_b = 1'b0;
    logic        req_ready_b, resp_valid_b, resp_err_b, busy_b;
    logic [31:0] resp_rdata_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rdata;
        bit          chk;
        logic        err;
        int          exp_edge;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          chk;
        logic        exp_err;
    } vec_t;
    vec_t tbl[10];

    mem_wait_unit #(.ADDR_W(10), .LATENCY(LAT_A)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    mem_wait_unit #(.ADDR_W(10), .LATENCY(LAT_B)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_we(1'b0),
        .req_addr(32'h40), .req_wdata(32'd0), .req_ready(req_ready_b),
        .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b), .busy(busy_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_resp: got resp_valid=1 at edge %0d required 0", cyc);
                end else begin
                    e = sb_q.pop_front();
                    $display("resp addr=%h rdata=%h err=%b edge=%0d", e.addr, resp_rdata, resp_err, cyc);
                    if (e.chk) check("rdata", resp_rdata, e.rdata);
                    check("err", {31'd0, resp_err}, {31'd0, e.err});
                    check("latency_edge", cyc, e.exp_edge);
                end
            end
        end
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input bit chk, input logic exp_err,
                        input bit push_exp);
        bit got = 1'b0;
        int acc;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) got = 1'b1;
        end
        if (!got) begin
            total_cnt++;
            $display("FAIL ready_timeout: got req_ready=0 for 50 cycles required 1");
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        acc = cyc + 1;
        @(posedge clk);
        if (push_exp)
            sb_q.push_back('{addr, exp_rdata, chk, exp_err,
                             acc + ((addr[1:0] != 2'b00) ? 0 : LAT_A)});
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1) == 1;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain_timeout: got %0d pending responses required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        int e0;
        int p;
        tbl[0] = '{1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
        tbl[1] = '{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 32'h13,   32'hBAD0BAD0, 32'h0,        1'b1, 1'b1};
        tbl[3] = '{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 32'h1004, 32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[5] = '{1'b0, 32'h0004, 32'h0,        32'h12345678, 1'b1, 1'b0};
        tbl[6] = '{1'b1, 32'h20,   32'h11112222, 32'h0,        1'b0, 1'b0};
        tbl[7] = '{1'b0, 32'h21,   32'h0,        32'h0,        1'b1, 1'b1};
        tbl[8] = '{1'b1, 32'h20,   32'h33334444, 32'h11112222, 1'b1, 1'b0};
        tbl[9] = '{1'b0, 32'h20,   32'h0,        32'h33334444, 1'b1, 1'b0};

        fork
            monitor();
        join_none

        // Reset held two cycles with a request present: reset wins, nothing accepted.
        req_valid = 1'b1;
        req_addr  = 32'h13;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_req_ready", {31'd0, req_ready}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            check("rst_resp_rdata", resp_rdata, 32'd0);
            check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        end
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        send(1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata,
                 tbl[i].chk, tbl[i].exp_err, 1'b1);
            drain();
        end
        check("hold_rdata", resp_rdata, 32'h33334444);
        check("hold_err", {31'd0, resp_err}, 32'd0);

        // Reset in the first WAIT cycle abandons the write and suppresses the response.
        send(1'b1, 32'h20, 32'hAAAA5555, 32'h0, 1'b0, 1'b0, 1'b0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("midrst_req_ready", {31'd0, req_ready}, 32'd0);
            check("midrst_busy", {31'd0, busy}, 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        send(1'b0, 32'h20, 32'h0, 32'h33334444, 1'b1, 1'b0, 1'b1);
        drain();

        // LATENCY=4 instance with req_valid held: an access every 6 cycles.
        @(negedge clk);
        check("b_ready_idle", {31'd0, req_ready_b}, 32'd1);
        req_valid_b = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < 3 * (LAT_B + 2); k++) begin
            @(negedge clk);
            p = (cyc - e0) % (LAT_B + 2);
            check("b_busy", {31'd0, busy_b}, {31'd0, p < LAT_B + 1});
            check("b_req_ready", {31'd0, req_ready_b}, {31'd0, p == LAT_B + 1});
            check("b_resp_valid", {31'd0, resp_valid_b}, {31'd0, p == LAT_B});
            if (p == LAT_B) begin
                $display("resp_b rdata=%h err=%b edge=%0d", resp_rdata_b, resp_err_b, cyc);
                check("b_err", {31'd0, resp_err_b}, 32'd0);
            end
        end
        req_valid_b = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        check("b_idle_after", {31'd0, busy_b}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
